// File: rtl/column_update.sv
// Column-store update engine: emits pivot columns in turn and subtracts tagged subtrahend bundles from the non-pivot columns.
// Optional macro COLUMN_UPDATE_SAT_EN selects saturating subtraction; when it is undefined, subtraction wraps.
module column_update #(
    parameter int MAT_SIZE = 5,
    parameter int DATWIDTH = 64,
    localparam int CW      = $clog2(MAT_SIZE) + 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           matLoad,
    input  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] matIn,
    output logic                                           pivotVld,
    input  logic                                           pivotRdy,
    output logic [MAT_SIZE-1:0][DATWIDTH-1:0]              pivotCol,
    output logic [CW-1:0]                                  pivotCnt,
    input  logic                                           subVld,
    output logic                                           subRdy,
    input  logic [CW-1:0]                                  opCnt,
    input  logic [MAT_SIZE-2:0][MAT_SIZE-1:0][DATWIDTH-1:0] columnSubstractor,
    output logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] matOut,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           tagErr
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] EMIT     = 3'd1;
    localparam logic [2:0] WAIT_SUB = 3'd2;
    localparam logic [2:0] UPDATE   = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]                                     state;
    logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] store;
    logic [MAT_SIZE-2:0][MAT_SIZE-1:0][DATWIDTH-1:0] sub_reg;
    logic [CW-1:0]                                  pivot_cnt;
    logic [CW-1:0]                                  next_cnt;
    logic                                           tag_err;

    function automatic logic [DATWIDTH-1:0] col_sub(input logic [DATWIDTH-1:0] a,
                                                    input logic [DATWIDTH-1:0] b);
        logic [DATWIDTH-1:0] d;
        d = a - b;
`ifdef COLUMN_UPDATE_SAT_EN
        // Signed overflow only occurs when the operand signs differ and the result sign flips.
        if ((a[DATWIDTH-1] != b[DATWIDTH-1]) && (d[DATWIDTH-1] != a[DATWIDTH-1]))
            d = a[DATWIDTH-1] ? {1'b1, {(DATWIDTH-1){1'b0}}} : {1'b0, {(DATWIDTH-1){1'b1}}};
`endif
        return d;
    endfunction

    assign next_cnt = pivot_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            store     <= '0;
            sub_reg   <= '0;
            pivot_cnt <= '0;
            tag_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (matLoad) begin
                        store     <= matIn;
                        pivot_cnt <= '0;
                        tag_err   <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (pivotRdy)
                        state <= WAIT_SUB;
                end
                WAIT_SUB: begin
                    if (subVld) begin
                        if (opCnt == pivot_cnt) begin
                            sub_reg <= columnSubstractor;
                            state   <= UPDATE;
                        end else begin
                            tag_err <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    // Bundle slot p maps onto column p below the pivot and p+1 above it, skipping the pivot.
                    for (int p = 0; p < MAT_SIZE - 1; p++) begin
                        for (int r = 0; r < MAT_SIZE; r++) begin
                            if (CW'(p) < pivot_cnt)
                                store[p][r] <= col_sub(store[p][r], sub_reg[p][r]);
                            else
                                store[p+1][r] <= col_sub(store[p+1][r], sub_reg[p][r]);
                        end
                    end
                    pivot_cnt <= next_cnt;
                    state     <= (next_cnt == CW'(MAT_SIZE)) ? DONE : EMIT;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pivotCol = '0;
        for (int c = 0; c < MAT_SIZE; c++) begin
            if ((state == EMIT) && (pivot_cnt == CW'(c)))
                pivotCol = store[c];
        end
    end

    assign pivotVld = (state == EMIT);
    assign subRdy   = (state == WAIT_SUB);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign pivotCnt = pivot_cnt;
    assign matOut   = store;
    assign tagErr   = tag_err;

endmodule
